pulse_stretch: RTL
==================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 4, the minimum number of cycles o_level is held high per accepted pulse (legal range 1..2^CNT_W-1).
REQ-002 SHALL provide parameter CNT_W, default 8, the width of the hold counter and the drop counter.
REQ-003 SHALL provide port i_clk  input  1  source-domain clock (fast side); the block has one clock, and all state is on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port i_pulse  input  1  single-cycle event, synchronous to i_clk.
REQ-006 SHALL provide port i_ack  input  1  acknowledge level from the slow domain, asynchronous to i_clk.
REQ-007 SHALL provide port o_level  output  1  stretched level for sampling by the slow domain, registered.
REQ-008 SHALL provide port o_busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL provide port o_drop  output  1  one-cycle pulse flagging an i_pulse that was rejected.
REQ-010 SHALL provide port o_drop_cnt  output  CNT_W  saturating count of rejected pulses.

Function
REQ-011 SHALL implement FSM states IDLE, HOLD, WAIT_ACK, WAIT_ACK_LOW.
REQ-012 SHALL pass i_ack through a two-flop synchronizer (ack_s); only ack_s is used internally, giving 2 cycles of latency.
REQ-013 SHALL accept i_pulse only in IDLE: next cycle state=HOLD, o_level=1, counter=HOLD_CYCLES-1.
REQ-014 In HOLD, SHALL decrement the counter each cycle; when it is 0, SHALL leave HOLD on the next edge.
REQ-015 SHALL keep o_level registered and high in HOLD and WAIT_ACK, and low in IDLE and WAIT_ACK_LOW.
REQ-016 In WAIT_ACK, SHALL move to WAIT_ACK_LOW when ack_s=1 (o_level falls the same edge); it SHALL wait indefinitely otherwise.
REQ-017 In WAIT_ACK_LOW, SHALL move to IDLE when ack_s=0.
REQ-018 SHALL treat i_pulse=1 in any non-IDLE state, including the final cycle before returning to IDLE, as rejected: o_drop=1 the next cycle, and o_drop_cnt increments.
REQ-019 o_drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 SHALL ignore an ack_s already high on entry to WAIT_ACK only after it has been low; a stale ack from a prior transaction is not accepted because WAIT_ACK_LOW guarantees it returned to 0.
REQ-021 o_busy SHALL be combinational from the state register, with no dependency on inputs.

Reset
REQ-022 On rst_n=0, SHALL asynchronously set state=IDLE, o_level=0, o_drop=0, o_drop_cnt=0, counter=0, and both synchronizer flops=0.
REQ-023 Reset asserted mid-transaction SHALL abort immediately; the first pulse after rst_n rises SHALL be accepted normally.

Configuration
REQ-024 Macro PULSE_STRETCH_ACK_EN defined SHALL enable the handshake: HOLD exits to WAIT_ACK, and REQ-016/017 apply.
REQ-025 Macro PULSE_STRETCH_ACK_EN undefined SHALL have HOLD exit directly to IDLE: o_level is high for exactly HOLD_CYCLES cycles, i_ack is ignored, and WAIT_ACK/WAIT_ACK_LOW and the synchronizer are not built.

Verification
REQ-026 No ACK_EN, HOLD_CYCLES=4, single i_pulse at cycle 10 -> o_level=1 cycles 11-14, o_busy=1 cycles 11-14, o_drop never asserted.
REQ-027 No ACK_EN, pulses at cycles 10 and 12 -> second rejected, o_drop=1 at cycle 13, o_drop_cnt=1.
REQ-028 ACK_EN, HOLD_CYCLES=4, pulse at cycle 10, i_ack rises at cycle 20 -> o_level high cycles 11 through 22, falls at 23; i_ack falls at 30 -> o_busy low from cycle 33.
REQ-029 ACK_EN, i_ack held high before the pulse -> o_level falls once the hold completes, and the block stays in WAIT_ACK_LOW until i_ack=0.
REQ-030 CNT_W=2, 5 rejected pulses -> o_drop_cnt reaches 3 and holds 3.
REQ-031 rst_n pulsed low during HOLD -> o_level=0 and o_busy=0 asynchronously, and a new pulse after release yields a full HOLD_CYCLES high.

Source files
------------

// File: rtl/pulse_stretch.sv
// -----------------------------------------------------------------------------
// pulse_stretch
//
// Purpose:
//   Stretches a single-cycle event from a fast clock domain into a level that
//   a slower domain can sample reliably. Every accepted pulse holds o_level
//   high for at least HOLD_CYCLES cycles. A pulse that arrives while a stretch
//   is still in progress is rejected. Each rejection is flagged on o_drop and
//   counted in a saturating counter.
//
// Build option:
//   PULSE_STRETCH_ACK_EN  When defined, a handshake is built. After the hold
//                         phase the block waits for the slow domain to raise
//                         i_ack, then waits for it to fall again before it
//                         returns to IDLE. When undefined, the hold phase goes
//                         straight back to IDLE, i_ack is ignored, and no
//                         synchronizer is built.
//
// Parameters:
//   HOLD_CYCLES  minimum number of cycles o_level is high per accepted pulse
//                (legal range 1 .. 2**CNT_W-1)
//   CNT_W        width of the hold counter and of the drop counter
//
// Ports:
//   i_clk       in   1      single clock; all state updates on its rising edge
//   rst_n       in   1      asynchronous active-low reset
//   i_pulse     in   1      single-cycle event, synchronous to i_clk
//   i_ack       in   1      acknowledge level from the slow domain (async)
//   o_level     out  1      registered stretched level
//   o_busy      out  1      high whenever the FSM is not in IDLE
//   o_drop      out  1      one-cycle flag for a rejected i_pulse
//   o_drop_cnt  out  CNT_W  saturating count of rejected pulses
// -----------------------------------------------------------------------------
module pulse_stretch #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             rst_n,
    input  logic             i_pulse,
    input  logic             i_ack,
    output logic             o_level,
    output logic             o_busy,
    output logic             o_drop,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        HOLD         = 2'd1,
        WAIT_ACK     = 2'd2,
        WAIT_ACK_LOW = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             drop_q, drop_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

`ifdef PULSE_STRETCH_ACK_EN
    // i_ack is asynchronous to i_clk. Only the second flop (ack_s_q) feeds any
    // logic, so a metastable first stage never reaches the FSM.
    logic ack_meta_q;
    logic ack_s_q;

    // NOTE: the synchronizer flops are cleared by reset. That way a stale ack
    //       cannot appear at the FSM in the first cycles after rst_n rises.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= i_ack;
            ack_s_q    <= ack_meta_q;
        end
    end
`else
    // Without the handshake, i_ack is deliberately left unconnected.
    logic unused_ack;
    assign unused_ack = i_ack;
`endif

    // -------------------------------------------------------------------------
    // Process 1: state and output registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only.
    //       Every flop then samples the pre-edge values, whatever order the
    //       statements are in.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal this block writes gets a default first. Any path
    //       that skips an assignment then holds the current value through the
    //       register instead of inferring a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_pulse) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                // The counter starts at HOLD_CYCLES-1. The state is left on
                // the edge after the cycle in which the counter reads zero,
                // which gives exactly HOLD_CYCLES cycles in HOLD.
                if (cnt_q == '0) begin
`ifdef PULSE_STRETCH_ACK_EN
                    state_d = WAIT_ACK;
`else
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
`ifdef PULSE_STRETCH_ACK_EN
            WAIT_ACK: begin
                if (ack_s_q) begin
                    state_d = WAIT_ACK_LOW;
                end
            end
            WAIT_ACK_LOW: begin
                // Return to IDLE only after the ack has gone low again. The
                // next transaction therefore cannot mistake this ack for its
                // own.
                if (!ack_s_q) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // o_level is taken from the next state. The registered level then
        // changes on the same edge as the state register.
        level_d    = (state_d == HOLD) || (state_d == WAIT_ACK);
        drop_d     = i_pulse && (state_q != IDLE);
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end
        o_busy = (state_q != IDLE);
    end

    assign o_level    = level_q;
    assign o_drop     = drop_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
